// File: rtl/bmac_pkg.sv
// Shared definitions for the BMAC accumulator: FSM encoding, sum guard width
// and the saturation limits for the default accumulator width.
package bmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // The internal sum is one bit wider than the accumulator, so an overflow
  // shows up as a disagreement between the two top bits.
  localparam int SUM_EXT = 1;

  localparam int ACC_WIDTH_DEF = 32;
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/bmac_sat_add.sv
// Combinational saturating add of the accumulator and one sign-extended
// partial sum. Reports whether the result had to be clamped.
module bmac_sat_add
  import bmac_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [IN_WIDTH-1:0]  addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  localparam int SUM_W = ACC_WIDTH + SUM_EXT;
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [SUM_W-1:0] acc_x;
  logic signed [SUM_W-1:0] add_x;
  logic signed [SUM_W-1:0] wide;

  // Returns {clamped, value}; clamps toward the sign of the wide result.
  function automatic logic [ACC_WIDTH:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1] != v[SUM_W-2]) begin
      return v[SUM_W-1] ? {1'b1, SAT_MIN} : {1'b1, SAT_MAX};
    end
    return {1'b0, v[ACC_WIDTH-1:0]};
  endfunction

  assign acc_x = {acc[ACC_WIDTH-1], acc};
  assign add_x = {{(SUM_W-IN_WIDTH){addend[IN_WIDTH-1]}}, addend};
  assign wide  = acc_x + add_x;
  assign {ovf, sum} = saturate(wide);

endmodule

// File: rtl/bmac_acc.sv
// Frame accumulator behind the BMAC stage: sums signed partial sums beat by
// beat with saturation and emits one held result per in_last-terminated frame.
module bmac_acc
  import bmac_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] out_beats
);

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sat;
  logic [CNT_WIDTH-1:0] beats;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf;
  logic                 beat_acc;
  logic                 res_acc;

  bmac_sat_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .acc    (acc),
    .addend (in_data),
    .sum    (sum),
    .ovf    (ovf)
  );

  assign beat_acc = in_valid & in_ready;
  assign res_acc  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; in_ready decodes state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACC: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? OUT : ACC;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, sticky saturation flag and saturating beat counter.
  // They double as the result registers while the result is offered.
  always_ff @(posedge clk) begin
    if (!rst_n || res_acc) begin
      acc   <= '0;
      sat   <= 1'b0;
      beats <= '0;
    end else if (beat_acc) begin
      acc   <= sum;
      sat   <= sat | ovf;
      if (beats != {CNT_WIDTH{1'b1}}) beats <= beats + 1'b1;
    end
  end

  assign out_data  = acc;
  assign out_sat   = sat;
  assign out_beats = beats;

endmodule

// File: tb/tb_bmac_acc.sv
// Bench for bmac_acc: a 32-bit and a 20-bit accumulator share one stimulus
// stream and are each compared against a plain-arithmetic frame model.
module tb_bmac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [15:0] in_data;

  logic        rdy_a, vld_a, sat_a;
  logic [31:0] data_a;
  logic [7:0]  beats_a;
  logic        rdy_b, vld_b, sat_b;
  logic [19:0] data_b;
  logic [7:0]  beats_b;

  int tests = 0;
  int fails = 0;
  int q[$];

  always #5 clk = ~clk;

  bmac_acc u_a (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (rdy_a),
    .in_data (in_data), .in_last (in_last), .out_valid (vld_a),
    .out_ready (out_ready), .out_data (data_a), .out_sat (sat_a), .out_beats (beats_a)
  );

  bmac_acc #(.ACC_WIDTH(20)) u_b (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (rdy_b),
    .in_data (in_data), .in_last (in_last), .out_valid (vld_b),
    .out_ready (out_ready), .out_data (data_b), .out_sat (sat_b), .out_beats (beats_b)
  );

  // Frame model: running sum clamped to a w-bit signed range after every beat.
  task automatic model(input int w, output longint s, output bit sat, output int nb);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    s = 0; sat = 0; nb = 0;
    foreach (q[i]) begin
      s += q[i];
      if (s > mx) begin s = mx; sat = 1; end
      else if (s < mn) begin s = mn; sat = 1; end
      if (nb < 255) nb++;
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit with_last);
    int t;
    int v;
    for (int i = 0; i < q.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      v = q[i];
      in_valid = 1'b1;
      in_data  = v[15:0];
      in_last  = with_last && (i == q.size() - 1);
      t = 0;
      while (!rdy_a && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready got %b want 1", rdy_a);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last-beat accept; checks, holds, then takes the result.
  task automatic check_result(input string name, input int hold);
    longint ea, eb;
    bit     sa, sb;
    int     na, nb;
    model(32, ea, sa, na);
    model(20, eb, sb, nb);
    tests++;
    if (vld_a !== 1'b1 || vld_b !== 1'b1) begin
      fails++; $display("FAIL %s latency: out_valid got %b/%b want 1/1", name, vld_a, vld_b);
    end
    tests++;
    if (data_a !== ea[31:0]) begin
      fails++; $display("FAIL %s data32: got 0x%h want 0x%h", name, data_a, ea[31:0]);
    end
    tests++;
    if (data_b !== eb[19:0]) begin
      fails++; $display("FAIL %s data20: got 0x%h want 0x%h", name, data_b, eb[19:0]);
    end
    tests++;
    if (sat_a !== sa || sat_b !== sb) begin
      fails++; $display("FAIL %s sat: got %b/%b want %b/%b", name, sat_a, sat_b, sa, sb);
    end
    tests++;
    if (beats_a !== na[7:0] || beats_b !== nb[7:0]) begin
      fails++; $display("FAIL %s beats: got %0d/%0d want %0d", name, beats_a, beats_b, na);
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      tests++;
      if (vld_a !== 1'b1 || rdy_a !== 1'b0 || rdy_b !== 1'b0 || data_a !== ea[31:0] ||
          data_b !== eb[19:0] || beats_a !== na[7:0] || sat_a !== sa) begin
        fails++;
        $display("FAIL %s hold%0d: vld %b rdy %b data 0x%h beats %0d want vld 1 rdy 0 data 0x%h beats %0d",
                 name, h, vld_a, rdy_a, data_a, beats_a, ea[31:0], na);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || rdy_a !== 1'b1 || rdy_b !== 1'b1 ||
        data_a !== 32'd0 || data_b !== 20'd0 || beats_a !== 8'd0 || sat_a !== 1'b0) begin
      fails++;
      $display("FAIL %s release: vld %b rdy %b data 0x%h beats %0d sat %b want 0 1 0 0 0",
               name, vld_a, rdy_a, data_a, beats_a, sat_a);
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || rdy_a !== 1'b1 || rdy_b !== 1'b1 ||
        data_a !== 32'd0 || data_b !== 20'd0 || sat_a !== 1'b0 || sat_b !== 1'b0 ||
        beats_a !== 8'd0 || beats_b !== 8'd0) begin
      fails++;
      $display("FAIL %s: vld %b rdy %b data 0x%h/0x%h sat %b beats %0d want 0 1 0 0 0",
               name, vld_a, rdy_a, data_a, data_b, sat_a, beats_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset");
  endtask

  task automatic test_two_beat();
    q = '{24, -16};
    send_frame(0, 1'b1);
    check_result("two_beat", 0);
  endtask

  task automatic test_hold();
    q = '{24};
    send_frame(0, 1'b1);
    check_result("hold", 5);
  endtask

  task automatic test_pos_sat();
    q = {};
    repeat (17) q.push_back(32767);
    send_frame(0, 1'b1);
    check_result("pos_sat17", 0);
    q = {};
    repeat (16) q.push_back(32767);
    send_frame(0, 1'b1);
    check_result("pos_16", 0);
  endtask

  task automatic test_neg_sat();
    q = {};
    repeat (17) q.push_back(-32768);
    send_frame(0, 1'b1);
    check_result("neg_sat17", 1);
    q = '{1};
    send_frame(0, 1'b1);
    check_result("sat_cleared", 0);
  endtask

  task automatic test_count();
    q = {};
    repeat (300) q.push_back(1);
    send_frame(0, 1'b1);
    check_result("count300", 0);
    send_frame(30, 1'b1);
    check_result("count300_gaps", 0);
  endtask

  task automatic test_abort();
    q = '{1000, -7, 300};
    send_frame(0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("abort_reset");
    q = '{5};
    send_frame(0, 1'b1);
    check_result("after_abort", 0);
  endtask

  task automatic test_random();
    int len;
    int v;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(40, 1);
      q = {};
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(3))
          0:       v = 32767;
          1:       v = -32768;
          default: v = $urandom_range(65535) - 32768;
        endcase
        q.push_back(v);
      end
      send_frame(20, 1'b1);
      check_result($sformatf("random%0d", f), $urandom_range(3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_beat();
    test_hold();
    test_pos_sat();
    test_neg_sat();
    test_count();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
